// File: rtl/m_mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter.
// State and owner values are fixed so traces read the same across builds.
package m_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_MA = 1'b1;

endpackage

// File: rtl/m_arb_latency_counter.sv
// Loadable down-counter with a zero flag.
// Times the fixed memory read latency for the arbiter.
module m_arb_latency_counter #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/m_mem_arbiter.sv
// IF/MA arbiter for a single-port fixed-latency memory.
// MA has priority; a starve counter forces IF through.
import m_mem_arbiter_pkg::*;

module m_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              w_clock,
  input  logic              w_reset,
  input  logic              w_if_req,
  input  logic [ADDR_W-1:0] w_if_addr,
  output logic              r_if_ack,
  output logic [DATA_W-1:0] r_if_rdata,
  output logic              w_if_stall,
  input  logic              w_ma_req,
  input  logic              w_ma_we,
  input  logic [ADDR_W-1:0] w_ma_addr,
  input  logic [DATA_W-1:0] w_ma_wdata,
  output logic              r_ma_ack,
  output logic [DATA_W-1:0] r_ma_rdata,
  output logic              w_ma_stall,
  output logic              r_mem_en,
  output logic              r_mem_we,
  output logic [ADDR_W-1:0] r_mem_addr,
  output logic [DATA_W-1:0] r_mem_wdata,
  input  logic [DATA_W-1:0] w_mem_rdata
);

  localparam int CW = $clog2(LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic          r_owner;
  logic [SW-1:0] r_starve;
  logic          w_grant;
  logic          w_pick_if;
  logic          w_zero;
  logic          w_done;
  logic          w_cnt_load;
  logic          w_cnt_dec;

  // The strobe cycle reloads the counter, so a stale zero cannot end WAIT early.
  assign w_cnt_load = (r_state == S_WAIT) && r_mem_en;
  assign w_cnt_dec  = (r_state == S_WAIT) && !r_mem_en;
  assign w_done     = w_cnt_dec && w_zero;

  m_arb_latency_counter #(
    .W(CW)
  ) u_lat_cnt (
    .i_clk      (w_clock),
    .i_rst      (w_reset),
    .i_load     (w_cnt_load),
    .i_load_val (CW'(LAT - 1)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_pick_if   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_if_req || w_ma_req) begin
          w_grant     = 1'b1;
          w_pick_if   = w_if_req &&
                        (!w_ma_req ||
                         (r_starve == SW'(STARVE_MAX)));
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_done) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clock) begin
    if (w_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      r_owner     <= OWN_IF;
      r_starve    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_ma_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_ma_rdata  <= '0;
    end else begin
      r_mem_en <= w_grant;
      r_if_ack <= w_done && (r_owner == OWN_IF);
      r_ma_ack <= w_done && (r_owner == OWN_MA);
      if (w_grant) begin
        r_owner     <= w_pick_if ? OWN_IF : OWN_MA;
        r_mem_we    <= !w_pick_if && w_ma_we;
        r_mem_addr  <= w_pick_if ? w_if_addr : w_ma_addr;
        r_mem_wdata <= w_pick_if ? '0 : w_ma_wdata;
        if (w_pick_if) begin
          r_starve <= '0;
        end else if (w_if_req &&
                     (r_starve != SW'(STARVE_MAX))) begin
          r_starve <= r_starve + SW'(1);
        end
      end
      if (w_done && (r_owner == OWN_IF)) begin
        r_if_rdata <= w_mem_rdata;
      end
      if (w_done && (r_owner == OWN_MA) && !r_mem_we) begin
        r_ma_rdata <= w_mem_rdata;
      end
    end
  end

  assign w_if_stall = w_if_req && !r_if_ack;
  assign w_ma_stall = w_ma_req && !r_ma_ack;

endmodule
